sm2tc_operand_loader: RTL

SM2TC_OPERAND_LOADER -- requirements
Module: sm2tc_operand_loader

---
 rtl/sm2tc_operand_loader_pkg.sv | 13 +
 rtl/sm2tc_operand_loader_conv.sv | 25 ++
 rtl/sm2tc_operand_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sm2tc_operand_loader_pkg.sv
// Shared definitions for the sign-magnitude to two's-complement operand loader.
package sm2tc_operand_loader_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        HOLD   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/sm2tc_operand_loader_conv.sv
// sm2tc_conv: combinational sign-magnitude to two's-complement conversion.
// Negative zero converts to 0 and is flagged on neg_zero.
module sm2tc_conv #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] sm,
    output logic [WIDTH-1:0] tc,
    output logic             neg_zero
);

    logic [WIDTH-1:0] mag_ext;
    logic             mag_zero;

    always_comb begin
        mag_ext  = {1'b0, sm[WIDTH-2:0]};
        mag_zero = (sm[WIDTH-2:0] == '0);
        neg_zero = sm[WIDTH-1] & mag_zero;
        if (sm[WIDTH-1] && !mag_zero) begin
            tc = ~mag_ext + WIDTH'(1);
        end else begin
            tc = mag_ext;
        end
    end

endmodule

// File: rtl/sm2tc_operand_loader.sv
// Loads two sign-magnitude operands, converts them to two's complement and holds the pair for an ALU.
// Optional macro NEG_ZERO_ERR_EN: reject negative zero with a one-cycle err pulse instead of normalizing it.
module sm2tc_operand_loader
    import sm2tc_operand_loader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_led,
    output logic [CNT_W-1:0] pair_cnt
`ifdef NEG_ZERO_ERR_EN
    ,
    output logic             err
`endif
);

    loader_state_e    state_q, state_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;

    logic [WIDTH-1:0] tc;
    logic             neg_zero;
    logic             accept;
    logic             xfer;
    logic             reject;
    logic [WIDTH-1:0] store_val;

    sm2tc_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .sm       (in_sm),
        .tc       (tc),
        .neg_zero (neg_zero)
    );

`ifdef NEG_ZERO_ERR_EN
    logic err_q, err_d;
    assign reject = neg_zero;
    assign err    = err_q;
`else
    assign reject = 1'b0;
`endif

    // Negative zero is already 0 from the converter; the explicit mux keeps the normalization visible.
    assign store_val = neg_zero ? '0 : tc;

    always_comb begin
        in_ready   = (state_q == WAIT_A) || (state_q == WAIT_B);
        out_valid  = (state_q == HOLD);
        accept     = in_valid & in_ready;
        xfer       = out_valid & out_ready;
        state_d    = state_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        pair_cnt_d = pair_cnt_q;
`ifdef NEG_ZERO_ERR_EN
        err_d      = accept & reject;
`endif
        unique case (state_q)
            WAIT_A: begin
                if (accept && !reject) begin
                    out_a_d = store_val;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (accept && !reject) begin
                    out_b_d = store_val;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    pair_cnt_d = pair_cnt_q + CNT_W'(1);
                    state_d    = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WAIT_A;
            out_a_q    <= '0;
            out_b_q    <= '0;
            pair_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

`ifdef NEG_ZERO_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign out_a    = out_a_q;
    assign out_b    = out_b_q;
    assign pair_cnt = pair_cnt_q;
    assign out_led  = out_valid & (out_a_q[WIDTH-1] | out_b_q[WIDTH-1]);

endmodule
